// File: rtl/ld_pkg.sv
// Shared state encoding, default geometry and width helper for the lane-detection ingress.
package ld_pkg;

    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, RESYNC} ld_state_t;

    localparam int LD_IMG_WIDTH  = 416;
    localparam int LD_IMG_LENGTH = 416;
    localparam int LD_RGB_WIDTH  = 24;
    localparam int LD_PPC        = 2;

    // Counter width that never collapses to zero bits (PPC=1 still needs a lane register).
    function automatic int ld_w(input int n);
        return ($clog2(n) > 0) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ld_beat_unpacker.sv
// Holds one PPC-pixel beat and shifts it out one pixel per transfer; pixel 0 is valid the cycle after load.
// Beat ready is high when empty or when the last lane is leaving, so a stream of beats sustains 1 pixel/cycle.
module ld_beat_unpacker
    import ld_pkg::*;
#(
    parameter int PPC       = LD_PPC,
    parameter int RGB_WIDTH = LD_RGB_WIDTH,
    parameter int LANE_W    = ld_w(LD_PPC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_load,
    input  logic [RGB_WIDTH*PPC-1:0] i_beat_dat,
    input  logic                     i_pix_rdy,
    output logic                     o_beat_rdy,
    output logic                     o_pix_vld,
    output logic [RGB_WIDTH-1:0]     o_pix_dat,
    output logic [LANE_W-1:0]        o_lane
);

    logic [RGB_WIDTH*PPC-1:0] r_dat;
    logic                     r_full;
    logic [LANE_W-1:0]        r_lane;
    logic                     w_last;

    assign w_last     = (r_lane == LANE_W'(PPC - 1));
    assign o_beat_rdy = !r_full || (w_last && i_pix_rdy);
    assign o_pix_vld  = r_full;
    assign o_pix_dat  = r_dat[int'(r_lane)*RGB_WIDTH +: RGB_WIDTH];
    assign o_lane     = r_lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dat  <= '0;
            r_full <= 1'b0;
            r_lane <= '0;
        end else if (i_load) begin
            r_dat  <= i_beat_dat;
            r_full <= 1'b1;
            r_lane <= '0;
        end else if (r_full && i_pix_rdy) begin
            if (w_last) r_full <= 1'b0;
            else        r_lane <= r_lane + LANE_W'(1);
        end
    end

endmodule

// File: rtl/ld_axis_ingress.sv
// AXI4-Stream video to 1 pixel/cycle with row/col/eol/eof tags; framing FSM and 1-cycle error pulses.
// Optional saturating err_count port when LD_INGRESS_ERR_CNT_EN is defined.
module ld_axis_ingress
    import ld_pkg::*;
#(
    parameter int IMG_WIDTH  = LD_IMG_WIDTH,
    parameter int IMG_LENGTH = LD_IMG_LENGTH,
    parameter int RGB_WIDTH  = LD_RGB_WIDTH,
    parameter int PPC        = LD_PPC,
    parameter int AXI_WIDTH  = RGB_WIDTH * PPC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AXI_WIDTH-1:0]        s_axi_video_tdata,
    input  logic                        s_axi_video_tvalid,
    output logic                        s_axi_video_ready,
    input  logic                        s_axi_video_tlast,
    input  logic                        s_axi_video_tuser,
    output logic [RGB_WIDTH-1:0]        m_pix_data,
    output logic                        m_pix_valid,
    input  logic                        m_pix_ready,
    output logic [ld_w(IMG_WIDTH)-1:0]  m_pix_col,
    output logic [ld_w(IMG_LENGTH)-1:0] m_pix_row,
    output logic                        m_pix_eol,
    output logic                        m_pix_eof,
    output logic                        frame_done,
    output logic                        err_early_eol,
    output logic                        err_late_eol,
    output logic                        err_sof_mid
`ifdef LD_INGRESS_ERR_CNT_EN
    ,
    output logic [15:0]                 err_count
`endif
);

    localparam int COL_W  = ld_w(IMG_WIDTH);
    localparam int ROW_W  = ld_w(IMG_LENGTH);
    localparam int LANE_W = ld_w(PPC);

    ld_state_t          r_state, w_nstate;
    logic [ROW_W-1:0]   r_row, r_brow, w_nrow, w_jrow;
    logic [COL_W-1:0]   r_col, r_bcol, w_ncol, w_jcol;
    logic               r_beol, r_beof, w_eol, w_eof;
    logic               r_e_early, r_e_late, r_e_sof;
    logic               w_e_early, w_e_late, w_e_sof;
    logic               w_acc, w_load, w_end, w_lrow, w_beat_rdy;
    logic [LANE_W-1:0]  w_lane;
    logic               w_last_lane;

    ld_beat_unpacker #(.PPC(PPC), .RGB_WIDTH(RGB_WIDTH), .LANE_W(LANE_W)) u_unpack (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_beat_dat (s_axi_video_tdata),
        .i_pix_rdy  (m_pix_ready),
        .o_beat_rdy (w_beat_rdy),
        .o_pix_vld  (m_pix_valid),
        .o_pix_dat  (m_pix_data),
        .o_lane     (w_lane)
    );

    assign s_axi_video_ready = w_beat_rdy;
    assign w_acc             = s_axi_video_tvalid && w_beat_rdy;

    // Position of the next beat is tracked at acceptance; tags for the held beat are latched with it.
    always_comb begin
        w_jrow    = s_axi_video_tuser ? '0 : r_row;
        w_jcol    = s_axi_video_tuser ? '0 : r_col;
        w_end     = (int'(w_jcol) + PPC) == IMG_WIDTH;
        w_lrow    = int'(w_jrow) == (IMG_LENGTH - 1);
        w_load    = 1'b0;
        w_nstate  = r_state;
        w_nrow    = r_row;
        w_ncol    = r_col;
        w_eol     = 1'b0;
        w_eof     = 1'b0;
        w_e_early = 1'b0;
        w_e_late  = 1'b0;
        w_e_sof   = 1'b0;
        if (w_acc) begin
            w_load  = s_axi_video_tuser || (r_state == ACTIVE);
            w_e_sof = s_axi_video_tuser && (r_state != WAIT_SOF);
            if (!w_load) begin
                if (r_state == RESYNC && s_axi_video_tlast) w_nstate = ACTIVE;
            end else if (s_axi_video_tlast || w_end) begin
                w_eol     = 1'b1;
                w_eof     = w_lrow;
                w_e_early = s_axi_video_tlast && !w_end;
                w_e_late  = !s_axi_video_tlast;
                w_ncol    = '0;
                w_nrow    = w_lrow ? '0 : w_jrow + ROW_W'(1);
                w_nstate  = w_lrow ? WAIT_SOF : (s_axi_video_tlast ? ACTIVE : RESYNC);
            end else begin
                w_ncol    = w_jcol + COL_W'(PPC);
                w_nrow    = w_jrow;
                w_nstate  = ACTIVE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= WAIT_SOF;
            r_row     <= '0;
            r_col     <= '0;
            r_brow    <= '0;
            r_bcol    <= '0;
            r_beol    <= 1'b0;
            r_beof    <= 1'b0;
            r_e_early <= 1'b0;
            r_e_late  <= 1'b0;
            r_e_sof   <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_row     <= w_nrow;
            r_col     <= w_ncol;
            r_e_early <= w_e_early;
            r_e_late  <= w_e_late;
            r_e_sof   <= w_e_sof;
            if (w_load) begin
                r_brow <= w_jrow;
                r_bcol <= w_jcol;
                r_beol <= w_eol;
                r_beof <= w_eof;
            end
        end
    end

    assign w_last_lane   = (w_lane == LANE_W'(PPC - 1));
    assign m_pix_row     = r_brow;
    assign m_pix_col     = r_bcol + COL_W'(w_lane);
    assign m_pix_eol     = m_pix_valid && r_beol && w_last_lane;
    assign m_pix_eof     = m_pix_valid && r_beof && w_last_lane;
    assign frame_done    = m_pix_eof && m_pix_ready;
    assign err_early_eol = r_e_early;
    assign err_late_eol  = r_e_late;
    assign err_sof_mid   = r_e_sof;

`ifdef LD_INGRESS_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err_cnt <= '0;
        else if ((r_e_early || r_e_late || r_e_sof) && r_err_cnt != 16'hFFFF)
            r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_ld_axis_ingress.sv
// Directed bench for ld_axis_ingress at 8x4 pixels, PPC=2: clean, backpressured, early/late eol, mid-frame sof, reset.
`timescale 1ns/1ps
module tb_ld_axis_ingress;

    localparam int W = 8, L = 4, PPC = 2, RGB = 24, AXW = RGB * PPC;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [AXW-1:0]   tdata = '0;
    logic             tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
    logic             s_rdy;
    logic [RGB-1:0]   pix;
    logic             pvld, prdy;
    logic [2:0]       pcol;
    logic [1:0]       prow;
    logic             peol, peof, fdone, e_early, e_late, e_sof;
`ifdef LD_INGRESS_ERR_CNT_EN
    logic [15:0]      err_count;
`endif

    int n_vec = 0, n_err = 0;
    int seq = 0;
    bit bp_en = 1'b0;
    int c_early = 0, c_late = 0, c_sof = 0, c_fdone = 0, stab_err = 0;
    int g0, fd0, ee0, el0, es0, st0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ld_axis_ingress #(.IMG_WIDTH(W), .IMG_LENGTH(L), .RGB_WIDTH(RGB), .PPC(PPC)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_axi_video_tdata  (tdata),
        .s_axi_video_tvalid (tvalid),
        .s_axi_video_ready  (s_rdy),
        .s_axi_video_tlast  (tlast),
        .s_axi_video_tuser  (tuser),
        .m_pix_data         (pix),
        .m_pix_valid        (pvld),
        .m_pix_ready        (prdy),
        .m_pix_col          (pcol),
        .m_pix_row          (prow),
        .m_pix_eol          (peol),
        .m_pix_eof          (peof),
        .frame_done         (fdone),
        .err_early_eol      (e_early),
        .err_late_eol       (e_late),
        .err_sof_mid        (e_sof)
`ifdef LD_INGRESS_ERR_CNT_EN
        ,
        .err_count          (err_count)
`endif
    );

    function automatic logic [RGB-1:0] pix_of(input int k);
        return RGB'(24'h100000 + k);
    endfunction

    function automatic logic [31:0] rec(input logic [RGB-1:0] d, input int row, input int col,
                                        input logic eol, input logic eof);
        return {1'b0, eof, eol, 2'(row), 3'(col), d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: captures transfers, counts pulses, flags any tag change while stalled.
    initial begin
        logic [31:0] cur, prev;
        bit stall;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            cur = rec(pix, int'(prow), int'(pcol), peol, peof);
            if (stall && pvld && cur != prev) stab_err++;
            if (rst_n && pvld && prdy) got_q.push_back(cur);
            if (e_early) c_early++;
            if (e_late)  c_late++;
            if (e_sof)   c_sof++;
            if (fdone)   c_fdone++;
            stall = pvld && !prdy;
            prev  = cur;
        end
    end

    initial begin
        int k;
        k = 0;
        prdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                prdy = (k % 4 == 0) || (k % 4 == 3);
                k++;
            end else begin
                prdy = 1'b1;
            end
        end
    end

    task automatic beat(input bit u, input bit l, input bit keep, input int row, input int c,
                        input bit eol, input bit eof);
        int n;
        n = 0;
        tdata  = {pix_of(seq + 1), pix_of(seq)};
        tuser  = u;
        tlast  = l;
        tvalid = 1'b1;
        if (keep) begin
            exp_q.push_back(rec(pix_of(seq), row, c, 1'b0, 1'b0));
            exp_q.push_back(rec(pix_of(seq + 1), row, c + 1, eol, eof));
        end
        seq += 2;
        forever begin
            @(negedge clk);
            n++;
            if (s_rdy || n > 200) break;
        end
        if (n > 200) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic row(input int r, input bit sof);
        for (int b = 0; b < 4; b++)
            beat(sof && b == 0, b == 3, 1'b1, r, 2 * b, b == 3, b == 3 && r == L - 1);
    endtask

    task automatic snap();
        g0  = got_q.size();
        fd0 = c_fdone;
        ee0 = c_early;
        el0 = c_late;
        es0 = c_sof;
        st0 = stab_err;
    endtask

    task automatic drain();
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag);
        int n;
        n = got_q.size() - g0;
        chk({tag, "_npix"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            chk({tag, "_pix"}, got_q[g0 + i], exp_q[i]);
        exp_q.delete();
        g0 = got_q.size();
    endtask

    task automatic check_counts(input string tag, input int fd, input int ee, input int el, input int es);
        chk({tag, "_frame_done"}, c_fdone - fd0, fd);
        chk({tag, "_err_early"},  c_early - ee0, ee);
        chk({tag, "_err_late"},   c_late - el0, el);
        chk({tag, "_err_sof"},    c_sof - es0, es);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, s_rdy, 1);
        chk({tag, "_valid"}, pvld, 0);
        chk({tag, "_data"},  pix, 0);
        chk({tag, "_tags"},  {prow, pcol, peol, peof}, 0);
        chk({tag, "_pulses"}, {fdone, e_early, e_late, e_sof}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle("rst");
`ifdef LD_INGRESS_ERR_CNT_EN
        chk("rst_err_count", err_count, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle("post_rst");

        // 1: clean frame
        snap();
        for (int r = 0; r < L; r++) row(r, r == 0);
        drain();
        check_stream("s1");
        check_counts("s1", 1, 0, 0, 0);

        // 2: backpressure 1,0,0,1
        bp_en = 1'b1;
        snap();
        for (int r = 0; r < L; r++) row(r, r == 0);
        drain();
        bp_en = 1'b0;
        drain();
        check_stream("s2");
        check_counts("s2", 1, 0, 0, 0);
        chk("s2_stable", stab_err - st0, 0);

        // 3: early tlast on beat 2 of row 1
        snap();
        row(0, 1'b1);
        beat(0, 0, 1, 1, 0, 0, 0);
        beat(0, 0, 1, 1, 2, 0, 0);
        beat(0, 1, 1, 1, 4, 1, 0);
        row(2, 1'b0);
        row(3, 1'b0);
        drain();
        chk("s3_total", got_q.size() - g0, 30);
        check_stream("s3");
        check_counts("s3", 1, 1, 0, 0);

        // 4: missing tlast on row 0, tlast two beats later
        snap();
        beat(1, 0, 1, 0, 0, 0, 0);
        beat(0, 0, 1, 0, 2, 0, 0);
        beat(0, 0, 1, 0, 4, 0, 0);
        beat(0, 0, 1, 0, 6, 1, 0);
        beat(0, 0, 0, 0, 0, 0, 0);
        beat(0, 1, 0, 0, 0, 0, 0);
        row(1, 1'b0);
        row(2, 1'b0);
        row(3, 1'b0);
        drain();
        check_stream("s4");
        check_counts("s4", 1, 0, 1, 0);

        // 5: tuser at row 2 col 4 restarts the frame
        snap();
        row(0, 1'b1);
        row(1, 1'b0);
        beat(0, 0, 1, 2, 0, 0, 0);
        beat(0, 0, 1, 2, 2, 0, 0);
        beat(1, 0, 1, 0, 0, 0, 0);
        beat(0, 0, 1, 0, 2, 0, 0);
        beat(0, 0, 1, 0, 4, 0, 0);
        beat(0, 1, 1, 0, 6, 1, 0);
        row(1, 1'b0);
        row(2, 1'b0);
        row(3, 1'b0);
        drain();
        check_stream("s5");
        check_counts("s5", 1, 0, 0, 1);
`ifdef LD_INGRESS_ERR_CNT_EN
        chk("s5_err_count", err_count, 3);
`endif

        // 6: garbage before sof, reset mid-frame, then a clean frame
        snap();
        for (int i = 0; i < 3; i++) beat(0, 0, 0, 0, 0, 0, 0);
        row(0, 1'b1);
        beat(0, 0, 1, 1, 0, 0, 0);
        beat(0, 0, 1, 1, 2, 0, 0);
        drain();
        rst_n = 1'b0;
        #1;
        check_idle("s6_in_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle("s6_post_rst");
`ifdef LD_INGRESS_ERR_CNT_EN
        chk("s6_err_count", err_count, 0);
`endif
        check_stream("s6a");
        for (int r = 0; r < L; r++) row(r, r == 0);
        drain();
        check_stream("s6b");
        check_counts("s6", 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
